speed_pulse_gen: RTL and testbench
==================================

# speed_pulse_gen

Programmable encoder-pulse and gate-window generator: the transmit-side counterpart of the speed-measurement counter. It produces a gate waveform (high = counting window, low = reset/display phase) and, during each high window, exactly `rate` evenly spaced pulses on `signal`. The receiver can then be driven and checked in-system or on the bench without a motor. It sits beside the speed counter in the car top level and is selectable in place of the real encoder input.

## Interface
- `GATE_PERIOD`, default 50_000_000: total gate period in `clk` cycles.
- `GATE_HIGH`, default 25_000_000: high (counting) portion of the period in cycles; must be < `GATE_PERIOD`.
- `PULSE_W`, default 4: `signal` high time per pulse, in cycles.
- `RAMP_STEP`, default 16: maximum applied-rate change per window; used only with ramp enabled.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: run enable.
- `rate` input 14: target pulses per high window, unsigned.
- `gate` output 1: gate window; high during the HIGH state.
- `signal` output 1: pulse train.
- `issued` output 14: pulses emitted in the last completed window.
- `win_done` output 1: one-cycle strobe at the end of each window.
- `sat` output 1: target rate was clamped for the current window.

## Operation
- MAX_RATE = GATE_HIGH / (2·PULSE_W), using integer division. `applied` = min(target, MAX_RATE); `sat` = (target > MAX_RATE).
- States:
  - IDLE → LOW when `en`=1.
  - LOW lasts GATE_PERIOD−GATE_HIGH cycles, then → HIGH.
  - HIGH lasts GATE_HIGH cycles, then → LOW if `en`, else → IDLE.
- `rate` is sampled only on the LOW→HIGH transition. Changes at any other time take effect at the next window.
- NCO, accumulator width ≥ 14 + clog2(GATE_HIGH)+1:
  - At HIGH entry, acc=0.
  - Each HIGH cycle: acc += applied. If acc ≥ GATE_HIGH, then acc −= GATE_HIGH and a pulse starts.
  - The k-th pulse starts at window cycle ceil(k·GATE_HIGH/applied)−1, counting from 0. Exactly `applied` pulses start per window; the last one starts at cycle GATE_HIGH−1 at the latest.
- Pulse stretcher: `signal` stays high for PULSE_W cycles. A pulse in progress at window end completes during LOW. No pulse ever starts outside HIGH.
- At the HIGH→LOW or HIGH→IDLE transition, `issued` ← the window's pulse count and `win_done`=1 for one cycle.
- `en` falling mid-window does not truncate the window; the full window completes first.
- rate=0: no pulses, `issued`=0.

## Timing
- Reset values: gate=0, signal=0, issued=0, win_done=0, sat=0; state IDLE; acc, counters and pulse stretcher cleared.
- `rst` wins over every other event. If asserted mid-pulse or mid-window, all outputs are 0 on the following cycle.
- All outputs are registered. `gate` rises on the first HIGH cycle and falls on the first cycle after HIGH.
- A pulse start is visible on `signal` on the same cycle the crossing is registered, so window cycle c maps to output cycle c.
- From `en` rising in IDLE, the first `gate` high occurs 1 + (GATE_PERIOD−GATE_HIGH) cycles later.

## Configuration
- `SPEED_PULSE_GEN_RAMP_EN` defined: `applied` slews toward the clamped target by at most RAMP_STEP per window, up or down. `applied` resets to 0, so the first window after reset is limited to ≤ RAMP_STEP.
- Macro undefined: `applied` = clamped target immediately at each window start. RAMP_STEP is ignored.

## Structure
- Package `speed_gen_pkg` holds:
  - RATE_W=14.
  - The state enum {IDLE, LOW, HIGH}.
  - The accumulator width function.
- Sub-module `speed_gen_nco` contains the accumulator, crossing compare, pulse stretcher and per-window pulse counter. The top module holds the state machine, rate latch/clamp/ramp and output registers.

## Test plan
All scenarios use GATE_PERIOD=100, GATE_HIGH=50, PULSE_W=2, giving MAX_RATE=12.
- rate=5, en=1 → each window has `signal` rising at window cycles 9, 19, 29, 39, 49; `win_done` pulses once with `issued`=5, sat=0.
- rate=0 → `gate` toggles 50/50, `signal` stays 0, `issued`=0.
- rate=100 → 12 pulses per window, sat=1, `issued`=12, and no two pulses overlap.
- rate changed 5→8 at HIGH cycle 20 → that window still gives 5; the next window gives 8.
- en dropped at HIGH cycle 10 with rate=5 → the window completes with `issued`=5, then IDLE with gate=0; rst at HIGH cycle 25 → all outputs 0 next cycle.
- Ramp enabled, RAMP_STEP=2, rate 0→8 → `issued` sequence is 2, 4, 6, 8, 8. With the macro off → 8, 8.

Source files
------------

// File: rtl/speed_gen_pkg.sv
// speed_gen_pkg: shared width, state encoding and accumulator sizing for speed_pulse_gen.
//   RATE_W : width of the rate / pulse-count fields
//   state_e: IDLE (stopped), LOW (reset/display phase), HIGH (counting window)
//   acc_w  : NCO accumulator width able to hold acc + applied without overflow
package speed_gen_pkg;

   localparam int RATE_W = 14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_e;

   function automatic int acc_w(input int gate_high);
      return RATE_W + $clog2(gate_high) + 1;
   endfunction

endpackage

// File: rtl/speed_gen_nco.sv
// speed_gen_nco: phase accumulator, pulse stretcher and per-window pulse counter.
//   clk, rst : clock, synchronous active-high reset
//   start_i  : next cycle is window cycle 0 (accumulator and counter restart)
//   run_i    : next cycle is a later window cycle
//   step_i   : applied rate for the window being stepped into
//   signal_o : pulse train, PULSE_W cycles high per pulse
//   count_o  : pulses started so far in the current window
// The accumulator is advanced on the edge that enters each window cycle, so a
// crossing is registered and shown on signal_o in that same window cycle.
module speed_gen_nco
   import speed_gen_pkg::*;
#(
   parameter int GATE_HIGH = 25_000_000,
   parameter int PULSE_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              run_i,
   input  logic [RATE_W-1:0] step_i,
   output logic              signal_o,
   output logic [RATE_W-1:0] count_o
);

   localparam int AW  = acc_w(GATE_HIGH);
   localparam int PWW = $clog2(PULSE_W + 1);
   localparam logic [AW-1:0] GH = AW'(GATE_HIGH);

   logic [AW-1:0]     acc_q, acc_d, sum;
   logic [PWW-1:0]    left_q, left_d;
   logic [RATE_W-1:0] cnt_q, cnt_d;
   logic              sig_q, sig_d, act, hit;

   always_comb begin
      act    = start_i | run_i;
      sum    = (start_i ? '0 : acc_q) + AW'(step_i);
      hit    = act && (sum >= GH);
      acc_d  = !act ? acc_q : hit ? sum - GH : sum;
      // left counts the remaining high cycles after the current one
      left_d = hit ? PWW'(PULSE_W - 1) : (left_q != '0) ? left_q - PWW'(1) : '0;
      sig_d  = hit | (left_q != '0);
      cnt_d  = (start_i ? '0 : cnt_q) + RATE_W'(hit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         left_q <= '0;
         cnt_q  <= '0;
         sig_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         left_q <= left_d;
         cnt_q  <= cnt_d;
         sig_q  <= sig_d;
      end
   end

   assign signal_o = sig_q;
   assign count_o  = cnt_q;

endmodule

// File: rtl/speed_pulse_gen.sv
// speed_pulse_gen: gate-window and evenly spaced encoder-pulse generator.
//   clk, rst : clock, synchronous active-high reset
//   en       : run enable, sampled in IDLE and at each window end
//   rate     : target pulses per window, latched at LOW->HIGH
//   gate     : high during the counting window
//   signal   : pulse train from the NCO
//   issued   : pulse count of the last completed window
//   win_done : one-cycle strobe after each window
//   sat      : target exceeded MAX_RATE for the current window
// Optional: SPEED_PULSE_GEN_RAMP_EN slews the applied rate by at most
// RAMP_STEP per window; without it the clamped target applies at once.
module speed_pulse_gen
   import speed_gen_pkg::*;
#(
   parameter int GATE_PERIOD = 50_000_000,
   parameter int GATE_HIGH   = 25_000_000,
   parameter int PULSE_W     = 4,
   parameter int RAMP_STEP   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [RATE_W-1:0] rate,
   output logic              gate,
   output logic              signal,
   output logic [RATE_W-1:0] issued,
   output logic              win_done,
   output logic              sat
);

   localparam int LOW_LEN  = GATE_PERIOD - GATE_HIGH;
   localparam int TW       = $clog2(GATE_PERIOD + 1);
   localparam int MAX_RATE = GATE_HIGH / (2 * PULSE_W);
   // a MAX_RATE beyond the rate field can never clamp
   localparam int MAX_CAP  = (MAX_RATE > 2**RATE_W - 1) ? 2**RATE_W - 1 : MAX_RATE;
   localparam logic [RATE_W-1:0] MAX_R = RATE_W'(MAX_CAP);

   state_e            state_q, state_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [RATE_W-1:0] applied_q, applied_d, tgt, step, issued_q, count;
   logic              gate_q, wd_q, sat_q, tmr_end, start, wend, run;

   always_comb begin
      tmr_end = tmr_q == '0;
      start   = (state_q == LOW) && tmr_end;
      wend    = (state_q == HIGH) && tmr_end;
      run     = (state_q == HIGH) && !tmr_end;
      state_d = (state_q == IDLE) ? (en ? LOW : IDLE) :
                !tmr_end ? state_q :
                (state_q == LOW) ? HIGH : (en ? LOW : IDLE);
      // tmr holds the cycles left in the current state after this one
      tmr_d   = start ? TW'(GATE_HIGH - 1) :
                ((state_q == IDLE) || tmr_end) ? TW'(LOW_LEN - 1) : tmr_q - TW'(1);
      tgt     = (rate > MAX_R) ? MAX_R : rate;
   end

`ifdef SPEED_PULSE_GEN_RAMP_EN
   localparam logic [RATE_W-1:0] STEP_R = RATE_W'(RAMP_STEP);

   always_comb
      applied_d = (tgt > applied_q) ?
                  ((tgt - applied_q > STEP_R) ? applied_q + STEP_R : tgt) :
                  ((applied_q - tgt > STEP_R) ? applied_q - STEP_R : tgt);
`else
   // RAMP_STEP has no effect without the ramp
   localparam int unused_ramp_step = RAMP_STEP;

   always_comb
      applied_d = tgt;
`endif

   // the first window cycle must already use the newly latched rate
   assign step = start ? applied_d : applied_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         tmr_q     <= '0;
         applied_q <= '0;
         gate_q    <= 1'b0;
         wd_q      <= 1'b0;
         sat_q     <= 1'b0;
         issued_q  <= '0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         applied_q <= start ? applied_d : applied_q;
         sat_q     <= start ? (rate > MAX_R) : sat_q;
         gate_q    <= state_d == HIGH;
         wd_q      <= wend;
         issued_q  <= wend ? count : issued_q;
      end
   end

   speed_gen_nco #(
      .GATE_HIGH(GATE_HIGH),
      .PULSE_W  (PULSE_W)
   ) u_nco (
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
      .run_i   (run),
      .step_i  (step),
      .signal_o(signal),
      .count_o (count)
   );

   assign gate     = gate_q;
   assign win_done = wd_q;
   assign issued   = issued_q;
   assign sat      = sat_q;

endmodule

// File: tb/tb_speed_pulse_gen.sv
// tb_speed_pulse_gen: table, directed and random checks of speed_pulse_gen against a window/pulse-schedule model.
module tb_speed_pulse_gen;

   localparam int GP    = 100;
   localparam int GHI   = 50;
   localparam int PW    = 2;
   localparam int LOWL  = GP - GHI;
   localparam int MAXR  = GHI / (2 * PW);
   localparam int RSTEP = 2;

   typedef struct {
      int rate;
      int exp_iss;
      bit exp_sat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [13:0] rate = '0;
   logic        gate, signal, win_done, sat;
   logic [13:0] issued;

   always #5 clk = ~clk;

   speed_pulse_gen #(
      .GATE_PERIOD(GP),
      .GATE_HIGH  (GHI),
      .PULSE_W    (PW),
      .RAMP_STEP  (RSTEP)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .rate    (rate),
      .gate    (gate),
      .signal  (signal),
      .issued  (issued),
      .win_done(win_done),
      .sat     (sat)
   );

   int   vectors = 0, errs = 0;
   int   ph = 0, tnow = 0, last_start = -1000, app_m = 0, wcount = 0, exp_iss = 0;
   bit   running = 0;
   bit   starts[GHI];
   logic exp_gate = 0, exp_sig = 0, exp_wd = 0, exp_sat = 0;

   function automatic int clampr(int r);
      return r > MAXR ? MAXR : r;
   endfunction

   // ph is the position in the gate period: [0,LOWL) low phase, [LOWL,GP) window.
   // Each window gets a schedule of pulse start cycles ceil(k*GHI/applied)-1.
   task automatic model();
      tnow++;
      exp_wd = 0;
      if (rst) begin
         running = 0; ph = 0; app_m = 0; exp_sat = 0; exp_iss = 0; last_start = -1000;
      end else if (!running) begin
         if (en) begin running = 1; ph = 0; end
      end else begin
         ph++;
         if (ph == LOWL) begin
            int c;
            c = clampr(int'(rate));
`ifdef SPEED_PULSE_GEN_RAMP_EN
            app_m = (c > app_m) ? ((c - app_m > RSTEP) ? app_m + RSTEP : c)
                                : ((app_m - c > RSTEP) ? app_m - RSTEP : c);
`else
            app_m = c;
`endif
            exp_sat = int'(rate) > MAXR;
            wcount = 0;
            foreach (starts[i]) starts[i] = 0;
            for (int k = 1; k <= app_m; k++) starts[(k * GHI + app_m - 1) / app_m - 1] = 1;
         end
         if (ph == GP) begin
            exp_wd = 1; exp_iss = wcount; running = en; ph = 0;
         end
      end
      exp_gate = running && ph >= LOWL;
      if (exp_gate && starts[ph - LOWL]) begin last_start = tnow; wcount++; end
      exp_sig = (tnow - last_start) < PW;
   endtask

   task automatic step();
      @(posedge clk);
      model();
      #1;
      vectors++;
      if (gate !== exp_gate || signal !== exp_sig || win_done !== exp_wd ||
          sat !== exp_sat || issued !== 14'(exp_iss)) begin
         errs++;
         $display("FAIL cycle %0d: got gate=%b signal=%b win_done=%b sat=%b issued=%0d, want %b %b %b %b %0d",
                  tnow, gate, signal, win_done, sat, issued, exp_gate, exp_sig, exp_wd, exp_sat, exp_iss);
      end
   endtask

   task automatic chk(string name, int got, int want);
      vectors++;
      if (got != want) begin
         errs++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic wait_win();
      bit done = 0;
      for (int i = 0; i < 300; i++) if (!done) begin step(); done = exp_wd; end
      if (!done) chk("win_timeout", 0, 1);
   endtask

   task automatic win_until();
      bit ok = 0;
      for (int i = 0; i < 12; i++) if (!ok) begin wait_win(); ok = app_m == clampr(int'(rate)); end
      if (!ok) chk("settle_timeout", 0, 1);
   endtask

   task automatic wait_high(int c);
      bit ok = 0;
      for (int i = 0; i < 300; i++) if (!ok) begin step(); ok = exp_gate && (ph - LOWL == c); end
      if (!ok) chk("high_timeout", 0, 1);
   endtask

   initial begin
      vec_t tbl[10];
      int   rises[$];
      bit   prev;
`ifdef SPEED_PULSE_GEN_RAMP_EN
      int   ramp_exp[5] = '{2, 4, 6, 8, 8};
      int   chg_new = 7;
`else
      int   ramp_exp[5] = '{8, 8, 8, 8, 8};
      int   chg_new = 8;
`endif
      tbl = '{'{5, 5, 0}, '{0, 0, 0}, '{100, 12, 1}, '{12, 12, 0}, '{13, 12, 1},
              '{1, 1, 0}, '{16383, 12, 1}, '{7, 7, 0}, '{11, 11, 0}, '{2, 2, 0}};

      repeat (3) step();
      chk("rst_gate", int'(gate), 0);
      chk("rst_signal", int'(signal), 0);
      chk("rst_issued", int'(issued), 0);
      chk("rst_win_done", int'(win_done), 0);
      chk("rst_sat", int'(sat), 0);

      rst = 0; rate = 8; en = 1;
      for (int w = 0; w < 5; w++) begin
         wait_win();
         chk("ramp_issued", int'(issued), ramp_exp[w]);
      end

      for (int i = 0; i < 10; i++) begin
         rate = 14'(tbl[i].rate);
         win_until();
         chk("tbl_issued", int'(issued), tbl[i].exp_iss);
         chk("tbl_sat", int'(sat), int'(tbl[i].exp_sat));
      end

      rate = 5;
      win_until();
      wait_high(0);
      prev = signal;
      for (int c = 1; c < GHI; c++) begin
         step();
         if (signal && !prev) rises.push_back(c);
         prev = signal;
      end
      chk("rise_count", rises.size(), 5);
      for (int i = 0; i < rises.size() && i < 5; i++) chk("rise_pos", rises[i], 9 + 10 * i);

      wait_win();
      wait_high(20);
      rate = 8;
      wait_win();
      chk("chg_old_window", int'(issued), 5);
      wait_win();
      chk("chg_new_window", int'(issued), chg_new);

      rate = 5;
      win_until();
      wait_high(10);
      en = 0;
      wait_win();
      chk("endrop_issued", int'(issued), 5);
      repeat (60) step();
      chk("idle_gate", int'(gate), 0);

      en = 1; rate = 100;
      win_until();
      chk("sat_issued", int'(issued), 12);
      wait_high(25);
      chk("pre_rst_signal", int'(signal), 1);
      rst = 1;
      step();
      chk("mid_rst_gate", int'(gate), 0);
      chk("mid_rst_signal", int'(signal), 0);
      chk("mid_rst_issued", int'(issued), 0);
      chk("mid_rst_win_done", int'(win_done), 0);
      chk("mid_rst_sat", int'(sat), 0);
      rst = 0;

      for (int n = 0; n < 2500; n++) begin
         if ($urandom_range(0, 59) == 0)
            rate = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 20));
         if ($urandom_range(0, 199) == 0) en = ~en;
         rst = $urandom_range(0, 999) == 0;
         step();
      end
      rst = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
